// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 op codes, multiply/divide FSM encoding, edge constants.
// Pure declarations; no timing or backpressure of its own.
package rv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_e;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 != MULHU) && (f3 != DIVU) && (f3 != REMU);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == MUL) || (f3 == MULH) || (f3 == DIV) || (f3 == REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in next dividend bit, trial-subtract, keep or restore.
// Purely combinational, zero latency; no flow control.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            fits;

    assign shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    // A set top bit on the incoming remainder can only mean it already exceeds the divisor.
    assign fits    = rem_in[XLEN] | ~diff[XLEN+1];

    always_comb begin
        rem_out = shifted;
        quo_out = {quo_in[XLEN-2:0], 1'b0};
        if (fits) begin
            rem_out = diff[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide: 35 cycles start-to-done, 2 for divide-by-zero/overflow.
// Stalls the pipeline via md_busy while iterating; hold freezes the result in DONE.
module exe_muldiv
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            hold,
    input  logic            kill,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    md_state_e         state;
    logic [2:0]        op;
    logic [5:0]        cnt;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quo;
    logic              neg_res;
    logic              neg_rem;

    // Operand decode, used only on the IDLE->CALC/DONE transition.
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign a_neg    = rs1_is_signed(funct3) & rs1_data[XLEN-1];
    assign b_neg    = rs2_is_signed(funct3) & rs2_data[XLEN-1];
    assign a_mag_in = a_neg ? -rs1_data : rs1_data;
    assign b_mag_in = b_neg ? -rs2_data : rs2_data;
    assign div_zero = funct3[2] && (rs2_data == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? rs1_data : ALL_ONES;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : INT_MIN;
    end

    // Shift-add multiply step: conditionally add the multiplicand into the high half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nx;

    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, b_mag};
    assign prod_nx = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};

    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] quo_nx;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (b_mag),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -quo : quo;
    assign rem_fix  = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    always_comb begin
        fix_result = '0;
        case (op)
            MUL:                  fix_result = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:            fix_result = quo_fix;
            default:              fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= '0;
            cnt       <= '0;
            b_mag     <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            md_result <= '0;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= funct3;
                        cnt     <= '0;
                        b_mag   <= b_mag_in;
                        prod    <= {{XLEN{1'b0}}, a_mag_in};
                        quo     <= a_mag_in;
                        rem     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        if (div_zero || div_ovf) begin
                            md_result <= special_res;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (op[2]) begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                    end else begin
                        prod <= prod_nx;
                    end
                    if (cnt == 6'd31)
                        state <= FIX;
                end
                FIX: begin
                    md_result <= fix_result;
                    state     <= DONE;
                end
                DONE: begin
                    if (!hold)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces busy low even while the stalled pipeline still presents start.
    assign md_busy = rst && (((state == IDLE) && start && !kill) || (state == CALC) || (state == FIX));
    assign md_done = (state == DONE);

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: expected results queued at issue, checked when md_done rises.
module tb_exe_muldiv;
    import rv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        hold;
    logic        kill;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;

    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          npass = 0;
    int          ntot  = 0;

    exe_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .hold      (hold),
        .kill      (kill),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_result (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        exp_q.push_back(e);
    endtask

    // Cycle 0 is the IDLE cycle presenting start; latency counts cycles until md_done.
    task automatic wait_done(input string tag, input int exp_lat, input int hold_n,
                             input bit chained, input bit keep);
        int          lat;
        bit          seen;
        logic [31:0] e;
        logic [31:0] held;
        lat  = 0;
        seen = 1'b0;
        if (chained) @(negedge clk);
        #1;
        chk({tag, "_busy_c0"}, 32'(md_busy), 32'd1);
        while (!seen && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
            if (md_done) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
                chk({tag, "_busy_done"}, 32'(md_busy), 32'd0);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                chk({tag, "_result"}, md_result, e);
                held     = md_result;
                last_res = held;
                if (hold_n > 0) begin
                    hold = 1'b1;
                    repeat (hold_n) begin
                        @(negedge clk);
                        #1;
                        chk({tag, "_hold_done"}, 32'(md_done), 32'd1);
                        chk({tag, "_hold_result"}, md_result, held);
                        chk({tag, "_hold_busy"}, 32'(md_busy), 32'd0);
                    end
                    hold = 1'b0;
                end
                if (!keep) start = 1'b0;
            end else begin
                chk({tag, "_busy_run"}, 32'(md_busy), 32'd1);
            end
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        funct3   = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        hold     = 1'b0;
        kill     = 1'b0;
        last_res = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_result", md_result, 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);
        chk("reset_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk); issue(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB); wait_done("mul",    34, 0, 0, 0);
        @(negedge clk); issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_done("mulhu",  34, 0, 0, 0);
        @(negedge clk); issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000); wait_done("mulh",   34, 0, 0, 0);
        @(negedge clk); issue(MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF); wait_done("mulhsu", 34, 0, 0, 0);
        @(negedge clk); issue(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD); wait_done("div",    34, 0, 0, 0);
        @(negedge clk); issue(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF); wait_done("rem_hold", 34, 3, 0, 0);

        // Back-to-back: start stays high across DONE->IDLE with the next op already presented.
        @(negedge clk); issue(DIVU,   32'd100,      32'd7,         32'd14);        wait_done("divu",   34, 0, 0, 1);
        issue(REMU, 32'd100, 32'd7, 32'd2);                                        wait_done("remu_b2b", 34, 0, 1, 0);

        @(negedge clk); issue(DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF); wait_done("divu_z", 1, 0, 0, 0);
        @(negedge clk); issue(REM,    32'd5,        32'd0,         32'd5);         wait_done("rem_z",  1, 0, 0, 0);

        // Kill mid-CALC: result register keeps the previous value.
        @(negedge clk);
        issue(MUL, 32'd3, 32'd3, 32'd9);
        #1;
        chk("kill_busy_c0", 32'(md_busy), 32'd1);
        repeat (5) @(negedge clk);
        kill  = 1'b1;
        start = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("kill_busy", 32'(md_busy), 32'd0);
        chk("kill_done", 32'(md_done), 32'd0);
        chk("kill_result", md_result, last_res);

        @(negedge clk); issue(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("div_ovf", 1, 0, 0, 0);
        @(negedge clk); issue(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000); wait_done("rem_ovf", 1, 0, 0, 0);
        @(negedge clk); issue(MUL,    32'h1234_5678, 32'h10,        32'h2345_6780); wait_done("mul_lo", 34, 0, 0, 0);

        // Async reset at CALC cycle 10 with start still asserted.
        @(negedge clk);
        issue(DIV, 32'd1000, 32'd7, 32'd142);
        #1;
        chk("rst_busy_c0", 32'(md_busy), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_result", md_result, 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        void'(exp_q.pop_back());
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk); issue(REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F); wait_done("remu_post", 34, 0, 0, 0);
        @(negedge clk); issue(MULHU,  32'h8000_0000, 32'd4,         32'h0000_0002); wait_done("mulhu_post", 34, 0, 0, 0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
